mouse_line_drawer: RTL and testbench
====================================

MOUSE_LINE_DRAWER -- requirements
Module: mouse_line_drawer

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter XW, default 10, meaning x coordinate width.
REQ-004 SHALL have parameter YW, default 10, meaning y coordinate width.
REQ-005 SHALL have parameter AW, default 19, meaning write address width.
REQ-006 SHALL have parameter THICK, default 2, legal range 1..4, meaning vertical pixels written per line point.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have ports MOUSE_X_POS (input, XW) and MOUSE_Y_POS (input, YW): pointer position.
REQ-010 SHALL have ports MOUSE_LEFT and MOUSE_RIGHT (input, 1 each): left = draw ink 1, right = erase 0.
REQ-011 SHALL have port wr_ready, input, 1 bit: framebuffer accepts the presented write.
REQ-012 SHALL have port write_addr, output, AW bits: pixel address y*H_RES + x.
REQ-013 SHALL have port write_enable, output, 1 bit: write request valid.
REQ-014 SHALL have port write_data, output, 1 bit: pixel value.
REQ-015 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE and LINE; write_addr, write_enable, write_data driven from registers.
REQ-017 SHALL clamp sampled inputs: x >= H_RES becomes H_RES-1, y >= V_RES becomes V_RES-1.
REQ-018 SHALL keep registers anchor (x,y) and pen_down; in IDLE with no button pressed, pen_down SHALL clear.
REQ-019 In IDLE, button pressed with pen_down=0: SHALL set anchor to clamped position, set pen_down, enter LINE for a one-point line at that position.
REQ-020 In IDLE, button pressed with pen_down=1 and position != anchor: SHALL enter LINE from anchor to position; position == anchor SHALL stay in IDLE.
REQ-021 Both buttons pressed: left wins, data 1; data value SHALL be latched at LINE entry and held for the whole line.
REQ-022 Mouse inputs SHALL be ignored while in LINE.
REQ-023 Line walk SHALL be integer Bresenham, no divider: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy, signed width max(XW,YW)+2.
REQ-024 Step: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy (both may apply in one step).
REQ-025 Each point SHALL emit sub-pixels k=0..THICK-1 at (x, y+k), in k order; sub-pixels with y+k >= V_RES SHALL be skipped with no write and no cycle spent.
REQ-026 Handshake: a write transfers on a cycle with write_enable=1 and wr_ready=1; while wr_ready=0, write_addr/write_data SHALL hold stable and write_enable stay 1.
REQ-027 With wr_ready held 1, SHALL issue one write per cycle, no bubbles between sub-pixels or points.
REQ-028 Latency: first write_enable SHALL assert on the cycle after the IDLE start decision.
REQ-029 After the last sub-pixel of end point transfers, SHALL set anchor to end point, return to IDLE, deassert write_enable same edge.
REQ-030 Start point of a drag line SHALL be re-emitted (line includes both endpoints).

Reset
REQ-031 On rst=1, SHALL asynchronously force state IDLE, anchor (0,0), pen_down 0, write_enable 0, write_addr 0, write_data 0, busy 0, regardless of clk, including mid-line; no partial line resumes after release.

Verification
REQ-032 THICK=2, reset, MOUSE_LEFT=1 at (10,20), wr_ready=1 -> writes 12810 then 13450, data 1, busy for 2 cycles, then IDLE.
REQ-033 Continue left held, move to (13,20) -> 8 writes 12810,13450,12811,13451,12812,13452,12813,13453; anchor (13,20).
REQ-034 THICK=1, MOUSE_RIGHT=1 at (0,0) then drag to (3,3) -> writes 0, then 0,641,1282,1923, data 0.
REQ-035 THICK=2, hold wr_ready=0 for 3 cycles during first write at (10,20) -> write_addr 12810 stable 4 cycles, then 13450.
REQ-036 THICK=2, left press at (5,479) -> only 306565 written, busy 1 cycle; then press at (700,500) -> clamped (639,479), only 307199 written.
REQ-037 Assert rst mid-line between clock edges -> write_enable, busy drop immediately; after release no writes until a new press.

Source files
------------

// File: rtl/mouse_line_drawer.sv
// Mouse-driven line drawer: walks a Bresenham line from the last pen position to the
// pointer and streams THICK-pixel-tall writes into a 1-bit framebuffer.
//
// state | meaning
// IDLE  | waiting for a button press or a pointer move while the pen is down
// LINE  | emitting sub-pixel writes for the current line, mouse inputs ignored
module mouse_line_drawer #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int XW    = 10,
   parameter int YW    = 10,
   parameter int AW    = 19,
   parameter int THICK = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [XW-1:0] MOUSE_X_POS,
   input  logic [YW-1:0] MOUSE_Y_POS,
   input  logic          MOUSE_LEFT,
   input  logic          MOUSE_RIGHT,
   input  logic          wr_ready,
   output logic [AW-1:0] write_addr,
   output logic          write_enable,
   output logic          write_data,
   output logic          busy
);

   localparam int W = ((XW > YW) ? XW : YW) + 2;

   typedef enum logic {IDLE, LINE} state_t;

   state_t               state;
   logic [XW-1:0]        anchor_x, cur_x, end_x;
   logic [YW-1:0]        anchor_y, cur_y, end_y;
   logic                 pen_down;
   logic signed [W-1:0]  err, dx, dy;
   logic                 sx_neg, sy_neg;
   logic [2:0]           k;

   function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return AW'(y) * AW'(H_RES) + AW'(x);
   endfunction

   logic [XW-1:0]       pos_x, x0;
   logic [YW-1:0]       pos_y, y0;
   logic                button, start;
   logic signed [W-1:0] x0s, x1s, y0s, y1s, ddx, ddy, abs_dx, abs_dy;

   always_comb begin
      pos_x  = (32'(MOUSE_X_POS) >= 32'(H_RES)) ? XW'(H_RES - 1) : MOUSE_X_POS;
      pos_y  = (32'(MOUSE_Y_POS) >= 32'(V_RES)) ? YW'(V_RES - 1) : MOUSE_Y_POS;
      button = MOUSE_LEFT | MOUSE_RIGHT;
      start  = button && (!pen_down || pos_x != anchor_x || pos_y != anchor_y);
      // a fresh press draws a single point at the pointer; a drag starts at the anchor
      x0     = pen_down ? anchor_x : pos_x;
      y0     = pen_down ? anchor_y : pos_y;
      x0s    = $signed(W'(x0));
      x1s    = $signed(W'(pos_x));
      y0s    = $signed(W'(y0));
      y1s    = $signed(W'(pos_y));
      ddx    = x1s - x0s;
      ddy    = y1s - y0s;
      abs_dx = (ddx < 0) ? -ddx : ddx;
      abs_dy = (ddy < 0) ? -ddy : ddy;
   end

   logic signed [W:0]   e2;
   logic                step_x, step_y, at_end, next_sub_ok;
   logic signed [W-1:0] err_n;
   logic [XW-1:0]       nx;
   logic [YW-1:0]       ny;

   always_comb begin
      e2          = $signed({err, 1'b0});
      step_x      = (e2 >= dy);
      step_y      = (e2 <= dx);
      err_n       = err + (step_x ? dy : W'(0)) + (step_y ? dx : W'(0));
      nx          = step_x ? (sx_neg ? cur_x - XW'(1) : cur_x + XW'(1)) : cur_x;
      ny          = step_y ? (sy_neg ? cur_y - YW'(1) : cur_y + YW'(1)) : cur_y;
      at_end      = (cur_x == end_x) && (cur_y == end_y);
      // sub-pixels below the bottom edge are skipped without spending a cycle
      next_sub_ok = (32'(k) + 32'd1 < 32'(THICK)) &&
                    (32'(cur_y) + 32'(k) + 32'd1 < 32'(V_RES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         anchor_x     <= '0;
         anchor_y     <= '0;
         pen_down     <= 1'b0;
         cur_x        <= '0;
         cur_y        <= '0;
         end_x        <= '0;
         end_y        <= '0;
         err          <= '0;
         dx           <= '0;
         dy           <= '0;
         sx_neg       <= 1'b0;
         sy_neg       <= 1'b0;
         k            <= '0;
         write_addr   <= '0;
         write_enable <= 1'b0;
         write_data   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!button) begin
                  pen_down <= 1'b0;
               end else if (start) begin
                  if (!pen_down) begin
                     anchor_x <= pos_x;
                     anchor_y <= pos_y;
                     pen_down <= 1'b1;
                  end
                  cur_x        <= x0;
                  cur_y        <= y0;
                  end_x        <= pos_x;
                  end_y        <= pos_y;
                  dx           <= abs_dx;
                  dy           <= -abs_dy;
                  sx_neg       <= (x1s < x0s);
                  sy_neg       <= (y1s < y0s);
                  err          <= abs_dx - abs_dy;
                  k            <= '0;
                  write_addr   <= pix_addr(x0, y0);
                  write_data   <= MOUSE_LEFT;
                  write_enable <= 1'b1;
                  busy         <= 1'b1;
                  state        <= LINE;
               end
            end
            LINE: begin
               if (wr_ready) begin
                  if (next_sub_ok) begin
                     k          <= k + 3'd1;
                     write_addr <= write_addr + AW'(H_RES);
                  end else if (at_end) begin
                     anchor_x     <= end_x;
                     anchor_y     <= end_y;
                     write_enable <= 1'b0;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     cur_x      <= nx;
                     cur_y      <= ny;
                     err        <= err_n;
                     k          <= '0;
                     write_addr <= pix_addr(nx, ny);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_line_drawer.sv
// Scoreboard bench for mouse_line_drawer: a THICK=2 and a THICK=1 instance side by side,
// expected writes queued by the stimulus and popped by per-instance monitors.
module tb_mouse_line_drawer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [9:0]  mx2, my2, mx1, my1;
   logic        ml2, mr2, ml1, mr1, rdy2, rdy1;
   logic [18:0] addr2, addr1;
   logic        we2, wd2, busy2, we1, wd1, busy1;

   mouse_line_drawer #(.THICK(2)) u2 (
      .clk(clk), .rst(rst), .MOUSE_X_POS(mx2), .MOUSE_Y_POS(my2),
      .MOUSE_LEFT(ml2), .MOUSE_RIGHT(mr2), .wr_ready(rdy2),
      .write_addr(addr2), .write_enable(we2), .write_data(wd2), .busy(busy2));

   mouse_line_drawer #(.THICK(1)) u1 (
      .clk(clk), .rst(rst), .MOUSE_X_POS(mx1), .MOUSE_Y_POS(my1),
      .MOUSE_LEFT(ml1), .MOUSE_RIGHT(mr1), .wr_ready(rdy1),
      .write_addr(addr1), .write_enable(we1), .write_data(wd1), .busy(busy1));

   logic [19:0] q2[$], q1[$];
   bit          chk2 = 1'b1, chk1 = 1'b1;
   int          vectors = 0, errs = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push2(input int a, input bit d);
      logic [31:0] av;
      av = a;
      q2.push_back({d, av[18:0]});
   endtask

   task automatic push1(input int a, input bit d);
      logic [31:0] av;
      av = a;
      q1.push_back({d, av[18:0]});
   endtask

   always @(negedge clk) begin
      logic [19:0] e;
      if (!rst && chk2 && we2 && rdy2) begin
         if (q2.size() == 0) begin
            vectors++; errs++;
            $display("FAIL u2 unexpected write: got addr %0d expected none", addr2);
         end else begin
            e = q2.pop_front();
            check("u2 addr", int'(addr2), int'(e[18:0]));
            check("u2 data", int'(wd2), int'(e[19]));
         end
      end
   end

   always @(negedge clk) begin
      logic [19:0] e;
      if (!rst && chk1 && we1 && rdy1) begin
         if (q1.size() == 0) begin
            vectors++; errs++;
            $display("FAIL u1 unexpected write: got addr %0d expected none", addr1);
         end else begin
            e = q1.pop_front();
            check("u1 addr", int'(addr1), int'(e[18:0]));
            check("u1 data", int'(wd1), int'(e[19]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_busy(input bit thick2, output int n);
      n = 0;
      while ((thick2 ? busy2 : busy1) && n < 1000) begin
         n++;
         tick();
      end
   endtask

   int n, wc;

   initial begin
      mx2 = '0; my2 = '0; ml2 = 0; mr2 = 0; rdy2 = 1;
      mx1 = '0; my1 = '0; ml1 = 0; mr1 = 0; rdy1 = 1;
      rst = 1'b1;
      tick(); tick();
      check("reset we", int'(we2), 0);
      check("reset addr", int'(addr2), 0);
      check("reset data", int'(wd2), 0);
      check("reset busy", int'(busy2), 0);
      rst = 1'b0;
      tick();

      // single point at (10,20), two rows tall
      push2(12810, 1); push2(13450, 1);
      mx2 = 10'd10; my2 = 10'd20; ml2 = 1;
      tick();
      run_busy(1, n);
      check("point busy cycles", n, 2);

      // drag to (13,20) with start point re-emitted
      for (int x = 10; x <= 13; x++) begin
         push2(20 * 640 + x, 1);
         push2(21 * 640 + x, 1);
      end
      mx2 = 10'd13;
      tick();
      run_busy(1, n);
      check("drag busy cycles", n, 8);
      ml2 = 0; tick(); tick();

      // back-pressure on the first write
      push2(12810, 1); push2(13450, 1);
      rdy2 = 0; mx2 = 10'd10; my2 = 10'd20; ml2 = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("stall addr", int'(addr2), 12810);
         check("stall we", int'(we2), 1);
         if (i < 3) tick();
      end
      rdy2 = 1;
      run_busy(1, n);
      ml2 = 0; tick(); tick();

      // bottom row: second sub-pixel falls off the screen
      push2(306565, 1);
      mx2 = 10'd5; my2 = 10'd479; ml2 = 1;
      tick();
      run_busy(1, n);
      check("bottom busy cycles", n, 1);
      ml2 = 0; tick(); tick();

      // out-of-range pointer clamps to (639,479)
      push2(307199, 1);
      mx2 = 10'd700; my2 = 10'd500; ml2 = 1;
      tick();
      run_busy(1, n);
      check("clamp busy cycles", n, 1);
      ml2 = 0; tick(); tick();

      // reset in the middle of a long line
      chk2 = 0;
      mx2 = 10'd0; my2 = 10'd0; ml2 = 1;
      tick();
      run_busy(1, n);
      mx2 = 10'd200;
      tick();
      repeat (4) tick();
      check("midline busy", int'(busy2), 1);
      #2 rst = 1'b1;
      #1;
      check("async rst we", int'(we2), 0);
      check("async rst busy", int'(busy2), 0);
      check("async rst addr", int'(addr2), 0);
      ml2 = 0;
      tick();
      rst = 1'b0;
      chk2 = 1;
      wc = 0;
      repeat (20) begin
         @(negedge clk);
         if (we2) wc++;
      end
      check("writes after reset", wc, 0);
      tick();

      // anchor was cleared by reset: new press is a single point
      push2(641, 1); push2(1281, 1);
      mx2 = 10'd1; my2 = 10'd1; ml2 = 1;
      tick();
      run_busy(1, n);
      check("post-reset busy cycles", n, 2);
      ml2 = 0; tick();

      // THICK=1 erase: point at origin, then diagonal drag
      push1(0, 0);
      mx1 = 10'd0; my1 = 10'd0; mr1 = 1;
      tick();
      run_busy(0, n);
      check("erase point busy", n, 1);
      push1(0, 0); push1(641, 0); push1(1282, 0); push1(1923, 0);
      mx1 = 10'd3; my1 = 10'd3;
      tick();
      run_busy(0, n);
      check("erase diag busy", n, 4);
      mr1 = 0; tick(); tick();

      // both buttons: left wins
      push1(2, 1);
      mx1 = 10'd2; my1 = 10'd0; ml1 = 1; mr1 = 1;
      tick();
      run_busy(0, n);
      check("both buttons busy", n, 1);
      ml1 = 0; mr1 = 0;
      tick(); tick(); tick();

      check("u2 queue drained", q2.size(), 0);
      check("u1 queue drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
